// File: rtl/mic_stream_pkg.sv
// mic_stream_pkg
//   Shared definitions for the microphone streaming controller:
//   sample widths, the controller state encoding and the
//   offset-binary to two's-complement conversion.
package mic_stream_pkg;

  localparam int SMP_W = 16;  // sample width toward the I2S transmitter
  localparam int MIC_W = 12;  // raw pmodmic3 sample width

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  // Flipping the MSB of an offset-binary code yields two's complement.
  // The 12-bit result is then left-justified in the 16-bit word.
  function automatic logic [SMP_W-1:0] mic_to_smp(input logic [MIC_W-1:0] d);
    return {~d[MIC_W-1], d[MIC_W-2:0], {(SMP_W-MIC_W){1'b0}}};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO. The head entry is visible
//   on dout whenever the FIFO is not empty; dout reads as zero when empty.
//   A push into a full FIFO is accepted only if a pop happens in the same
//   cycle; otherwise it is discarded and the contents are left untouched.
// Ports
//   clk, rst      clock, asynchronous active-low reset
//   push, din     write request and data
//   pop           read request (ignored while empty)
//   dout          head entry (FWFT)
//   empty, full   occupancy flags
//   level         number of entries held, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_rd;
  logic             do_wr;

  assign empty = (count == '0);
  assign full  = (count == LW'(DEPTH));
  assign level = count;

  assign do_rd = pop && !empty;
  // When full, the slot at wr_ptr is the head being popped this cycle, so
  // overwriting it at the same edge is safe.
  assign do_wr = push && (!full || do_rd);

  assign dout = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array has no reset; validity is tracked by count and
  // the pointers, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mic_stream_ctrl.sv
// mic_stream_ctrl
//   Bridges the pmodmic3 converter to an I2S sample stream. After each
//   enable a configurable number of samples is discarded while the
//   microphone settles; subsequent samples are converted to signed 16-bit
//   and buffered in a FWFT FIFO with a valid/ready output. Dropping en
//   stops conversions and lets the FIFO drain before returning to idle.
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   en                  1 = stream, 0 = stop and drain
//   mic_data, mic_wr    raw sample and its one-cycle strobe
//   mic_run             registered conversion enable toward pmodmic3
//   smp_data/valid/ready  sample output handshake
//   ovf, ovf_clr        sticky overflow flag and its clear pulse
//   level               samples currently buffered
module mic_stream_ctrl
  import mic_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int WARMUP     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [11:0]                   mic_data,
  input  logic                          mic_wr,
  output logic                          mic_run,
  output logic [15:0]                   smp_data,
  output logic                          smp_valid,
  input  logic                          smp_ready,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  state_t           state;
  logic [CNT_W-1:0] warm_cnt;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic             overflow;

  assign push     = (state == S_RUN) && mic_wr;
  assign pop      = smp_valid && smp_ready;
  assign overflow = push && fifo_full && !pop;

  assign smp_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (SMP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (mic_to_smp(mic_data)),
    .pop   (pop),
    .dout  (smp_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  // mic_run is assigned alongside each state change so it is a true
  // register that always matches the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      warm_cnt <= '0;
      mic_run  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            state    <= S_WARMUP;
            warm_cnt <= CNT_W'(WARMUP);
            mic_run  <= 1'b1;
          end
        end
        S_WARMUP: begin
          if (!en) begin
            state   <= S_IDLE;
            mic_run <= 1'b0;
          end else if (warm_cnt == '0) begin
            state <= S_RUN;
          end else if (mic_wr) begin
            // The sample that brings the count to zero is still discarded.
            warm_cnt <= warm_cnt - CNT_W'(1);
            if (warm_cnt == CNT_W'(1)) state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!en) begin
            state   <= S_DRAIN;
            mic_run <= 1'b0;
          end
        end
        S_DRAIN: begin
          // en is deliberately not looked at here: a new stream only
          // starts once the old samples have fully left the buffer.
          if (level == '0) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          mic_run <= 1'b0;
        end
      endcase
    end
  end

  // A simultaneous overflow wins over a clear so no event is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          ovf <= 1'b0;
    else if (overflow) ovf <= 1'b1;
    else if (ovf_clr)  ovf <= 1'b0;
  end

endmodule

// File: tb/tb_mic_stream_ctrl.sv
// tb_mic_stream_ctrl
//   Directed scoreboard bench for mic_stream_ctrl (FIFO_DEPTH=8, WARMUP=2).
//   Stimulus pushes each expected output sample into exp_q; an independent
//   monitor pops and compares on every completed handshake.
module tb_mic_stream_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [11:0] mic_data;
  logic        mic_wr;
  logic        mic_run;
  logic [15:0] smp_data;
  logic        smp_valid;
  logic        smp_ready;
  logic        ovf;
  logic        ovf_clr;
  logic [3:0]  level;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  mic_stream_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .WARMUP     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mic_data  (mic_data),
    .mic_wr    (mic_wr),
    .mic_run   (mic_run),
    .smp_data  (smp_data),
    .smp_valid (smp_valid),
    .smp_ready (smp_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr),
    .level     (level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mic_write(input logic [11:0] d, input bit accept, input logic [15:0] e);
    mic_data = d;
    mic_wr   = 1'b1;
    if (accept) exp_q.push_back(e);
    cyc(1);
    mic_wr = 1'b0;
  endtask

  task automatic warm_up();
    en = 1'b1;
    cyc(1);
    check("mic_run_on_enable", mic_run, 1);
    mic_write(12'h813, 1'b0, 16'h0);
    mic_write(12'h7B8, 1'b0, 16'h0);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while ((level != 0 || exp_q.size() != 0) && k < limit) begin
      cyc(1);
      k++;
    end
    check({name, "_level"}, level, 0);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  // Monitor: mid-cycle sampling, transfer completes at the next rising edge.
  always @(negedge clk) begin
    if (rst && smp_valid && smp_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_sample: got 0x%0h, expected none", smp_data);
      end else begin
        check("sample_out", smp_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; mic_data = '0; mic_wr = 1'b0;
    smp_ready = 1'b0; ovf_clr = 1'b0;
    cyc(2);
    check("rst_mic_run", mic_run, 0);
    check("rst_valid", smp_valid, 0);
    check("rst_data", smp_data, 0);
    check("rst_ovf", ovf, 0);
    check("rst_level", level, 0);
    rst = 1'b1;
    cyc(1);

    // Warm-up discard, conversion and single-cycle latency.
    smp_ready = 1'b1;
    warm_up();
    check("warmup_discard_level", level, 0);
    mic_write(12'h813, 1'b1, 16'h0130);
    check("latency_valid", smp_valid, 1);
    check("latency_data", smp_data, 16'h0130);
    mic_write(12'h7B8, 1'b1, 16'hFB80);
    wait_drain("basic", 20);

    // Fill to full, overflow on the ninth sample, stalled output is stable.
    smp_ready = 1'b0;
    mic_write(12'h800, 1'b1, 16'h0000);
    mic_write(12'hFFF, 1'b1, 16'h7FF0);
    mic_write(12'h000, 1'b1, 16'h8000);
    mic_write(12'h123, 1'b1, 16'h9230);
    mic_write(12'hABC, 1'b1, 16'h2BC0);
    mic_write(12'h555, 1'b1, 16'hD550);
    mic_write(12'hAAA, 1'b1, 16'h2AA0);
    mic_write(12'h7FF, 1'b1, 16'hFFF0);
    check("full_no_ovf_yet", ovf, 0);
    mic_write(12'h001, 1'b0, 16'h0);
    check("full_level", level, 8);
    check("ovf_set", ovf, 1);
    check("stall_valid", smp_valid, 1);
    check("stall_data", smp_data, 16'h0000);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Push and pop together while full.
    smp_ready = 1'b1;
    mic_write(12'h321, 1'b1, 16'hB210);
    smp_ready = 1'b0;
    check("full_pushpop_level", level, 8);
    check("full_pushpop_ovf", ovf, 0);

    // Overflow beats a simultaneous clear.
    ovf_clr = 1'b1;
    mic_write(12'h444, 1'b0, 16'h0);
    ovf_clr = 1'b0;
    check("ovf_clr_vs_event", ovf, 1);
    check("ovf_drop_level", level, 8);
    ovf_clr = 1'b1;
    cyc(1);
    ovf_clr = 1'b0;
    check("ovf_cleared_again", ovf, 0);
    smp_ready = 1'b1;
    wait_drain("full", 30);

    // Stop and drain.
    smp_ready = 1'b0;
    mic_write(12'h100, 1'b1, 16'h9000);
    mic_write(12'h200, 1'b1, 16'hA000);
    mic_write(12'h300, 1'b1, 16'hB000);
    en = 1'b0;
    cyc(1);
    check("drain_mic_run", mic_run, 0);
    mic_write(12'h9AB, 1'b0, 16'h0);
    check("drain_ignores_wr", level, 3);
    smp_ready = 1'b1;
    wait_drain("drain", 20);
    cyc(1);
    en = 1'b1;
    cyc(1);
    check("restart_after_idle", mic_run, 1);
    en = 1'b0;
    cyc(1);
    check("warmup_abort", mic_run, 0);
    cyc(1);

    // Asynchronous reset mid-stream with samples buffered.
    smp_ready = 1'b0;
    warm_up();
    mic_write(12'h810, 1'b1, 16'h0100);
    mic_write(12'h811, 1'b1, 16'h0110);
    mic_write(12'h812, 1'b1, 16'h0120);
    mic_write(12'h813, 1'b1, 16'h0130);
    mic_write(12'h814, 1'b1, 16'h0140);
    check("pre_reset_level", level, 5);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_mic_run", mic_run, 0);
    check("arst_valid", smp_valid, 0);
    check("arst_data", smp_data, 0);
    check("arst_level", level, 0);
    check("arst_ovf", ovf, 0);
    exp_q.delete();
    en = 1'b0;
    smp_ready = 1'b1;
    cyc(2);
    rst = 1'b1;
    check("post_release_valid", smp_valid, 0);
    cyc(1);
    check("post_release_valid_2", smp_valid, 0);

    // Random back-pressure, 100 samples, order and uniqueness via scoreboard.
    warm_up();
    begin
      int sent = 0;
      int iter = 0;
      logic [11:0] d;
      while (sent < 100 && iter < 5000) begin
        smp_ready = 1'($urandom_range(0, 1));
        if (level < 4'(DEPTH) && $urandom_range(0, 2) != 0) begin
          d = 12'($urandom);
          mic_data = d;
          mic_wr = 1'b1;
          exp_q.push_back({~d[11], d[10:0], 4'b0000});
          sent++;
        end else begin
          mic_wr = 1'b0;
        end
        cyc(1);
        iter++;
      end
      mic_wr = 1'b0;
      check("random_all_sent", sent, 100);
    end
    smp_ready = 1'b1;
    wait_drain("random", 200);
    check("random_no_ovf", ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mic_stream_ctrl.md
MIC_STREAM_CTRL -- requirements
Module: mic_stream_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, sample buffer depth; power of two, 4..64.
REQ-002 Parameter WARMUP, default 2, mic samples discarded after each enable.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  level; 1 = stream microphone samples, 0 = stop and drain.
REQ-006 mic_data  input  12  offset-binary sample from pmodmic3 data.
REQ-007 mic_wr  input  1  one-cycle strobe from pmodmic3 data_wr; mic_data valid in that cycle.
REQ-008 mic_run  output  1  enables pmodmic3 conversions; registered.
REQ-009 smp_data  output  16  signed two's-complement sample toward the I2S transmitter.
REQ-010 smp_valid  output  1  smp_data holds a sample.
REQ-011 smp_ready  input  1  consumer accepts; transfer when smp_valid && smp_ready.
REQ-012 ovf  output  1  sticky overflow flag.
REQ-013 ovf_clr  input  1  one-cycle pulse; clears ovf.
REQ-014 level  output  $clog2(FIFO_DEPTH)+1  samples currently buffered.

Function
REQ-015 FSM states: IDLE, WARMUP, RUN, DRAIN.
REQ-016 IDLE: mic_run=0; en=1 -> WARMUP, warm-up counter loaded with WARMUP.
REQ-017 WARMUP: mic_run=1; each mic_wr decrements counter, sample discarded; counter reaching 0 -> RUN; WARMUP=0 -> RUN on the next cycle.
REQ-018 RUN: mic_run=1; each mic_wr pushes converted sample; en=0 -> DRAIN.
REQ-019 DRAIN: mic_run=0; mic_wr ignored; FIFO keeps emptying via handshake; level=0 -> IDLE.
REQ-020 WARMUP with en=0 -> IDLE directly.
REQ-021 en=1 during DRAIN is ignored until IDLE is reached.
REQ-022 Conversion: smp = {~mic_data[11], mic_data[10:0], 4'b0000} (offset-binary to signed, left-justified).
REQ-023 Latency: mic_wr in cycle N, empty FIFO -> smp_valid=1 with that sample in cycle N+1.
REQ-024 smp_data/smp_valid stable while smp_valid=1 and smp_ready=0.
REQ-025 Order preserved: FIFO, first-word-fall-through on smp_data.
REQ-026 Full and mic_wr without pop in the same cycle: sample dropped, ovf=1 from next cycle, FIFO unchanged.
REQ-027 Full, mic_wr and pop in the same cycle: push accepted, level unchanged, no overflow.
REQ-028 Empty: smp_valid=0; smp_ready ignored.
REQ-029 Pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH inclusive.
REQ-030 ovf_clr and overflow event in the same cycle: ovf stays 1.
REQ-031 level updates one cycle after push/pop.

Reset
REQ-032 rst=0 asynchronously forces IDLE, mic_run=0, smp_valid=0, smp_data=0, ovf=0, level=0, pointers and counters 0.
REQ-033 Reset mid-stream discards buffered samples; no transfer in the first cycle after release.

Structure
REQ-034 Package mic_stream_pkg holds the state enum, sample width 16 and mic width 12 constants, and the conversion function.
REQ-035 One sub-module sync_fifo (parameterised width/depth, FWFT, full/empty/level) instantiated once.

Verification
REQ-036 en=1, WARMUP=2, mic_wr with 0x813, 0x7B8, 0x813, 0x7B8, smp_ready=1 -> first two dropped; outputs 0x0130 then 0xFB80.
REQ-037 smp_ready=0, 9 mic_wr at depth 8 -> level=8, ovf=1, ninth sample absent; ovf_clr -> ovf=0.
REQ-038 Full FIFO, mic_wr and smp_ready in the same cycle -> level stays 8, ovf=0, new sample last out.
REQ-039 en=0 with 3 buffered, smp_ready=1 -> mic_run=0 next cycle, 3 samples delivered, IDLE when level=0.
REQ-040 rst=0 asynchronously mid-RUN with 5 buffered -> all outputs 0 immediately, level=0.
REQ-041 smp_ready toggled randomly over 100 samples -> output sequence equals input sequence, no duplicates.
